onewire_master: RTL and testbench
=================================

# onewire_master

Byte-level 1-Wire bus master driving one open-drain bidirectional pad with external or pad pull-up. It converts accepted commands into bus waveforms on the pad's I/T/O pins: reset/presence, write byte, and read byte. Bytes are sent LSB first. It sits between an on-chip control bus (valid/ready command, pulsed response) and the bidirectional pull-up pad cell.

## Interface
- CLK_FREQ_HZ, 50_000_000, core clock frequency. Must be an integer multiple of 1 MHz and ≥ 2 MHz.
- clk  in  1  single clock. All logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0 = bus reset, 1 = write byte, 2 = read byte, 3 = CRC clear.
- cmd_data  in  8  byte for a write. Ignored for other ops.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_data  out  8  read byte. Holds its value until the next read.
- rsp_presence  out  1  presence result of the last bus reset (1 = device answered).
- crc8  out  8  running Dallas CRC-8, polynomial x^8+x^5+x^4+1.
- busy  out  1  high when the state is not IDLE.
- pad_t  out  1  pad tristate control. 1 = released (pulled high), 0 = driven.
- pad_i  out  1  pad drive value. Constant 0 (open-drain).
- pad_o  in  1  pad input, asynchronous to clk.

## Operation
- pad_o passes through a 2-flop synchronizer. The synchronized value is called `line`.
- Prescaler: a modulo-(CLK_FREQ_HZ/1e6) counter produces `us_tick`. Both the prescaler and `us_cnt` clear on every state entry, so each state starts on a full-microsecond boundary.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_op and cmd_data are latched on acceptance. Commands are never queued.
- States and transitions:
  - IDLE: pad_t=1.
    - op0 → RST_LOW.
    - op1 or op2 → SLOT_LOW with bit index 0.
    - op3 → RESP.
  - RST_LOW: pad_t=0 for 480 µs → RST_WAIT.
  - RST_WAIT: pad_t=1. At 70 µs, latch presence = ~line → RST_REC.
  - RST_REC: wait 410 µs → RESP.
  - SLOT_LOW: pad_t=0.
    - Writing 0: hold 60 µs.
    - Writing 1 or reading: hold 6 µs.
    - Then → SLOT_REL.
  - SLOT_REL: pad_t=1.
    - Reads only: sample `line` into shift[bit] at 15 µs after slot start, i.e. 9 µs into SLOT_REL.
    - Stay until the total slot time reaches 70 µs → SLOT_REC.
  - SLOT_REC: 5 µs recovery.
    - If bit = 7 → RESP.
    - Otherwise bit++ → SLOT_LOW.
  - RESP: rsp_valid=1 for one cycle → IDLE.
- Read slots use write-1 timing, so a read is a write of 0xFF with sampling.
- rsp_data updates in RESP only after op2.

## Timing
- Reset values:
  - pad_t=1, pad_i=0.
  - cmd_ready=1, busy=0, rsp_valid=0.
  - rsp_data=0x00, rsp_presence=0, crc8=0x00.
  - State IDLE, synchronizer flops = 1.
- Command latency, from the acceptance edge to the rsp_valid cycle:
  - Bus reset: 960 µs + 2 cycles.
  - Byte: 8×75 µs = 600 µs + 2 cycles.
  - CRC clear: 2 cycles.
- pad_t falls the cycle after the state register enters a low state. There is no combinational path from cmd_* to pad_t.
- Line sampling sees a 2-cycle synchronizer delay. The sample point is defined on the synchronized value.
- rst asserted mid-slot: the next edge gives pad_t=1, state IDLE, and no rsp_valid. A partially shifted byte is discarded. rsp_data, rsp_presence and crc8 all return to their reset values.
- cmd_valid held high during busy: ignored. It is accepted on the first IDLE cycle.
- A device holding the line low forever (bus stuck) does not stall the engine. Reads return 0x00 and a reset reports presence=1.

## Configuration
- ONEWIRE_CRC_EN:
  - Defined: each written or read bit updates crc8 in its SLOT_REC cycle, using b = bit ^ crc[0]; crc = (crc>>1) ^ (b ? 0x8C : 0). op3 clears crc8 to 0x00.
  - Undefined: crc8 is tied to 0x00, and op3 only produces a response pulse.

## Structure
- Package onewire_pkg holds:
  - op codes.
  - state enum.
  - µs constants: T_RST_LOW=480, T_PRES=70, T_RST_REC=410, T_W0=60, T_W1=6, T_RSAMP=15, T_SLOT=70, T_REC=5.
  - CRC polynomial 0x8C.
- One sub-module, onewire_us_timer, contains the prescaler, us_tick, the µs counter and clear.

## Test plan
- Bus reset with a bench device that pulls low from 15 µs to 135 µs after release: rsp_presence=1, rsp_valid exactly 960 µs + 2 cycles after acceptance. With no device: rsp_presence=0.
- Write 0xA5: low pulse widths measured on the pad, LSB first, are 6,60,6,60,60,6,60,6 µs. Slot period is 75 µs.
- Read with the device driving 0x3C (holding low 0–30 µs for 0-bits): rsp_data=0x3C.
- CRC (with ONEWIRE_CRC_EN): write 0x02,0x1C,0xB8,0x01,0x00,0x00,0x00 → crc8=0xA2. Then op3 → crc8=0x00.
- Assert rst for 1 cycle during bit 3 of a write: pad_t=1 on the next edge, no rsp_valid, cmd_ready=1.
- cmd_valid held high while busy with a second op: exactly one extra acceptance, on the first IDLE cycle after rsp_valid.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared definitions for the byte-level 1-Wire master: op codes, FSM states,
// microsecond timing constants and the Dallas CRC-8 step.
package onewire_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_WRITE   = 2'd1,
    OP_READ    = 2'd2,
    OP_CRC_CLR = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_RST_REC,
    S_SLOT_LOW,
    S_SLOT_REL,
    S_SLOT_REC,
    S_RESP
  } state_e;

  // Longest interval is 480 us, so 9 bits of microsecond count suffice.
  localparam int unsigned US_W = 9;

  localparam int unsigned T_RST_LOW = 480;
  localparam int unsigned T_PRES    = 70;
  localparam int unsigned T_RST_REC = 410;
  localparam int unsigned T_W0      = 60;
  localparam int unsigned T_W1      = 6;
  localparam int unsigned T_RSAMP   = 15;
  localparam int unsigned T_SLOT    = 70;
  localparam int unsigned T_REC     = 5;

  localparam logic [7:0] CRC_POLY = 8'h8C;

  // One bit of the reflected Dallas CRC-8 (x^8+x^5+x^4+1).
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return (crc >> 1) ^ (((b ^ crc[0]) == 1'b1) ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/onewire_us_timer.sv
// Microsecond time base for onewire_master: a modulo-DIV prescaler producing
// us_tick and a microsecond counter; both restart together on clr.
module onewire_us_timer
  import onewire_pkg::*;
#(
  parameter int unsigned DIV = 50
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  output logic            us_tick,
  output logic [US_W-1:0] us_cnt
);

  localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]   pre_q;
  logic [US_W-1:0] us_q;

  assign us_tick = (pre_q == PRE_LAST);
  assign us_cnt  = us_q;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_q <= '0;
      us_q  <= '0;
    end else if (us_tick) begin
      pre_q <= '0;
      us_q  <= us_q + US_W'(1);
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

endmodule

// File: rtl/onewire_master.sv
// Byte-level 1-Wire bus master (reset/presence, write byte, read byte, LSB first).
// Optional running CRC-8 is enabled by defining ONEWIRE_CRC_EN.
module onewire_master
  import onewire_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic [7:0] crc8,
  output logic       busy,
  output logic       pad_t,
  output logic       pad_i,
  input  logic       pad_o
);

  localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;

  // Counter values at the last microsecond of each interval; the state
  // changes on the tick that completes it, so intervals are exact.
  localparam logic [US_W-1:0] END_RST_LOW = US_W'(T_RST_LOW - 1);
  localparam logic [US_W-1:0] END_PRES    = US_W'(T_PRES - 1);
  localparam logic [US_W-1:0] END_RST_REC = US_W'(T_RST_REC - 1);
  localparam logic [US_W-1:0] END_W0      = US_W'(T_W0 - 1);
  localparam logic [US_W-1:0] END_W1      = US_W'(T_W1 - 1);
  localparam logic [US_W-1:0] END_REL0    = US_W'(T_SLOT - T_W0 - 1);
  localparam logic [US_W-1:0] END_REL1    = US_W'(T_SLOT - T_W1 - 1);
  localparam logic [US_W-1:0] END_RSAMP   = US_W'(T_RSAMP - T_W1 - 1);
  localparam logic [US_W-1:0] END_REC     = US_W'(T_REC - 1);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic            pres_q, pres_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [1:0]      sync_q;
  logic            pad_t_q, rsp_valid_q;
  logic            us_tick;
  logic [US_W-1:0] us_cnt;
  logic            line, wr_one, rec_done;

  assign line     = sync_q[1];
  assign rec_done = us_tick && (us_cnt == END_REC);

  onewire_us_timer #(.DIV(DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d != state_q),
    .us_tick (us_tick),
    .us_cnt  (us_cnt)
  );

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    pres_d  = pres_q;
    rdata_d = rdata_q;
    // Reads always use write-1 timing even after the sampled bit lands in shift_q.
    wr_one  = (op_q == OP_READ) || shift_q[bit_q];
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          bit_d = '0;
          unique case (op_e'(cmd_op))
            OP_RESET: state_d = S_RST_LOW;
            OP_WRITE: begin shift_d = cmd_data; state_d = S_SLOT_LOW; end
            OP_READ:  begin shift_d = 8'hFF;    state_d = S_SLOT_LOW; end
            default:  state_d = S_RESP;
          endcase
        end
      end
      S_RST_LOW:  if (us_tick && us_cnt == END_RST_LOW) state_d = S_RST_WAIT;
      S_RST_WAIT: begin
        if (us_tick && us_cnt == END_PRES) begin
          pres_d  = ~line;
          state_d = S_RST_REC;
        end
      end
      S_RST_REC:  if (us_tick && us_cnt == END_RST_REC) state_d = S_RESP;
      S_SLOT_LOW: if (us_tick && us_cnt == (wr_one ? END_W1 : END_W0)) state_d = S_SLOT_REL;
      S_SLOT_REL: begin
        if (op_q == OP_READ && us_tick && us_cnt == END_RSAMP) shift_d[bit_q] = line;
        if (us_tick && us_cnt == (wr_one ? END_REL1 : END_REL0)) state_d = S_SLOT_REC;
      end
      S_SLOT_REC: begin
        if (rec_done) begin
          if (bit_q == 3'd7) begin
            state_d = S_RESP;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = S_SLOT_LOW;
          end
        end
      end
      S_RESP: begin
        if (op_q == OP_READ) rdata_d = shift_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RESET;
      shift_q     <= '0;
      bit_q       <= '0;
      pres_q      <= 1'b0;
      rdata_q     <= '0;
      sync_q      <= 2'b11;
      pad_t_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      pres_q      <= pres_d;
      rdata_q     <= rdata_d;
      sync_q      <= {sync_q[0], pad_o};
      // Registered from state_q: no combinational path from cmd_* to the pad.
      pad_t_q     <= !(state_q == S_RST_LOW || state_q == S_SLOT_LOW);
      rsp_valid_q <= (state_q == S_RESP);
    end
  end

`ifdef ONEWIRE_CRC_EN
  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (state_q == S_SLOT_REC && rec_done) crc_d = crc8_step(crc_q, shift_q[bit_q]);
    else if (state_q == S_RESP && op_q == OP_CRC_CLR) crc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc8 = crc_q;
`else
  assign crc8 = 8'h00;
`endif

  assign cmd_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rdata_q;
  assign rsp_presence = pres_q;
  assign pad_t        = pad_t_q;
  assign pad_i        = 1'b0;

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master with a behavioural 1-Wire device on the pad
// and a response scoreboard; CRC expectations follow ONEWIRE_CRC_EN.
module tb_onewire_master;

  localparam int unsigned CLK_HZ   = 4_000_000;
  localparam int          US       = 4;            // clock cycles per microsecond
  localparam int          LAT_RST  = 960 * US + 2;
  localparam int          LAT_BYTE = 600 * US + 2;
  localparam int          LAT_CRC  = 2;
`ifdef ONEWIRE_CRC_EN
  localparam logic [7:0]  CRC_REF  = 8'hA2;
`else
  localparam logic [7:0]  CRC_REF  = 8'h00;
`endif

  typedef enum int {DEV_NONE, DEV_PRES, DEV_READ} dev_e;
  typedef struct {
    logic [7:0] data;
    logic       pres;
    int         lat;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_presence, busy, pad_t, pad_i, pad_o;
  logic [7:0] rsp_data, crc8;

  int   cyc = 0, acc_count = 0, acc_cyc = 0, rsp_count = 0, rsp_cyc = 0;
  int   nvec = 0, nerr = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   lows[$];
  int   starts[$];

  dev_e       dev_mode = DEV_NONE;
  logic       dev_stuck = 1'b0;
  logic [7:0] dev_byte = 8'h00;
  logic [2:0] dev_bit = 3'd0;
  int         pull_start = 0, pull_end = 0, fall_cyc = 0;
  logic       pt_prev = 1'b1;
  logic       dev_pull;

  logic [7:0] m_rdata = 8'h00;
  logic       m_pres = 1'b0;

  onewire_master #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_presence (rsp_presence),
    .crc8         (crc8),
    .busy         (busy),
    .pad_t        (pad_t),
    .pad_i        (pad_i),
    .pad_o        (pad_o)
  );

  // Open-drain bus: low if the master drives, the device pulls, or the bus is stuck.
  assign dev_pull = (cyc >= pull_start) && (cyc < pull_end);
  assign pad_o    = pad_t & ~dev_pull & ~dev_stuck;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready && !rst) begin
      acc_count <= acc_count + 1;
      acc_cyc   <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Device model and pulse monitor; pad_t is sampled on the falling clock edge.
  always @(negedge clk) begin
    if (dev_mode != DEV_READ) dev_bit = 3'd0;
    if (pt_prev && !pad_t) begin
      fall_cyc = cyc;
      if (dev_mode == DEV_READ) begin
        if (!dev_byte[dev_bit]) begin
          pull_start = cyc;
          pull_end   = cyc + 30 * US;
        end
        dev_bit = dev_bit + 3'd1;
      end
    end
    if (!pt_prev && pad_t) begin
      lows.push_back(cyc - fall_cyc);
      starts.push_back(fall_cyc);
      if (dev_mode == DEV_PRES && (cyc - fall_cyc) >= 400 * US) begin
        pull_start = cyc + 15 * US;
        pull_end   = cyc + 135 * US;
      end
    end
    pt_prev = pad_t;
  end

  // Response scoreboard.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_count++;
      rsp_cyc = cyc;
      check("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rsp_latency", cyc - acc_cyc, mon_e.lat);
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_presence", rsp_presence, mon_e.pres);
      end
    end
  end

  task automatic expect_op(input logic [1:0] op, input logic [7:0] val);
    exp_t e;
    if (op == 2'd0) m_pres = val[0];
    if (op == 2'd2) m_rdata = val;
    e.data = m_rdata;
    e.pres = m_pres;
    e.lat  = (op == 2'd0) ? LAT_RST : (op == 2'd3) ? LAT_CRC : LAT_BYTE;
    sb.push_back(e);
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [7:0] val);
    int n0;
    expect_op(op, val);
    n0        = acc_count;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    for (int i = 0; i < 50 && acc_count == n0; i++) @(negedge clk);
    cmd_valid = 1'b0;
    check("accept", acc_count - n0, 32'd1);
  endtask

  task automatic wait_rsp(input int n_before, input int budget);
    for (int i = 0; i < budget && rsp_count <= n_before; i++) @(negedge clk);
    check("rsp_wait", 32'(rsp_count > n_before), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int         n, n0, base, first_rsp, acc2, w_exp;
    logic [7:0] wr_byte;
    logic [7:0] crc_bytes [7];
    crc_bytes = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pad_t", pad_t, 32'd1);
    check("rst_pad_i", pad_i, 32'd0);
    check("rst_cmd_ready", cmd_ready, 32'd1);
    check("rst_busy", busy, 32'd0);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_rsp_data", rsp_data, 32'h00);
    check("rst_presence", rsp_presence, 32'd0);
    check("rst_crc8", crc8, 32'h00);

    // Bus reset with no device, then with a presence-answering device.
    n = rsp_count; issue(2'd0, 8'h00, 8'h00); wait_rsp(n, 1000 * US);
    dev_mode = DEV_PRES;
    n = rsp_count; issue(2'd0, 8'h00, 8'h01); wait_rsp(n, 1000 * US);
    dev_mode = DEV_NONE;

    // Write 0xA5: measured low widths and slot period.
    wr_byte = 8'hA5;
    base = lows.size();
    n = rsp_count; issue(2'd1, wr_byte, 8'h00); wait_rsp(n, 700 * US);
    check("a5_pulse_count", lows.size() - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < lows.size()) begin
        w_exp = wr_byte[i] ? 6 * US : 60 * US;
        check($sformatf("a5_low_bit%0d", i), lows[base + i], w_exp);
        if (i > 0) check($sformatf("a5_period_bit%0d", i), starts[base + i] - starts[base + i - 1], 75 * US);
      end
    end

    // Read with the device returning 0x3C.
    dev_byte = 8'h3C;
    dev_mode = DEV_READ;
    n = rsp_count; issue(2'd2, 8'h00, 8'h3C); wait_rsp(n, 700 * US);
    dev_mode = DEV_NONE;

    // Synchronous reset during bit 3 of a write.
    n = rsp_count; issue(2'd1, 8'h00, 8'h00);
    repeat ((3 * 75 + 30) * US) @(negedge clk);
    check("mid_slot_low", pad_t, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_pad_t", pad_t, 32'd1);
    check("mid_rst_cmd_ready", cmd_ready, 32'd1);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'h00);
    check("mid_rst_presence", rsp_presence, 32'd0);
    check("mid_rst_crc8", crc8, 32'h00);
    void'(sb.pop_back());
    m_rdata = 8'h00;
    m_pres  = 1'b0;
    repeat (700 * US) @(negedge clk);
    check("mid_rst_no_rsp", rsp_count - n, 32'd0);

    // Bus stuck low: read gives 0x00, reset reports presence.
    dev_stuck = 1'b1;
    n = rsp_count; issue(2'd2, 8'h00, 8'h00); wait_rsp(n, 700 * US);
    n = rsp_count; issue(2'd0, 8'h00, 8'h01); wait_rsp(n, 1000 * US);
    dev_stuck = 1'b0;

    // CRC over the reference ROM code, then clear.
    n = rsp_count; issue(2'd3, 8'h00, 8'h00); wait_rsp(n, 10 * US);
    check("crc_start", crc8, 32'h00);
    for (int i = 0; i < 7; i++) begin
      n = rsp_count; issue(2'd1, crc_bytes[i], 8'h00); wait_rsp(n, 700 * US);
    end
    check("crc_rom", crc8, CRC_REF);
    n = rsp_count; issue(2'd3, 8'h00, 8'h00); wait_rsp(n, 10 * US);
    check("crc_clear", crc8, 32'h00);

    // cmd_valid held through busy: one extra acceptance on the first IDLE cycle.
    n0 = acc_count;
    n  = rsp_count;
    expect_op(2'd1, 8'h00);
    expect_op(2'd3, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_data  = 8'h55;
    for (int i = 0; i < 50 && acc_count == n0; i++) @(negedge clk);
    cmd_op = 2'd3;
    for (int i = 0; i < 700 * US && acc_count == n0 + 1; i++) @(negedge clk);
    cmd_valid = 1'b0;
    first_rsp = rsp_cyc;
    acc2      = acc_cyc;
    check("busy_accepts", acc_count - n0, 32'd2);
    check("busy_accept_cycle", acc2, first_rsp);
    wait_rsp(n + 1, 20 * US);
    check("busy_rsp_count", rsp_count - n, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
